// File: rtl/ffs_dec_m.sv
`default_nettype none
// ============================================================================
// Module   : ffs_dec_m
// Brief    : Packet index accumulator; ORs one-hot decoded indices into a
//            mask and flags out-of-range and (with FFS_DEC_DUP_CHECK_EN)
//            repeated indices.
// Revision : 1.0
// ============================================================================
module ffs_dec_m #(
  parameter int   OUTPUT_WIDTH = 8,
  parameter logic SIDE         = 1'b0,
  localparam int  W            = (OUTPUT_WIDTH < 1) ? 1 : OUTPUT_WIDTH,
  localparam int  IDX_W        = $clog2((W < 2) ? 2 : W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_mask,
  output logic             out_dup,
  output logic             out_err
);

  if (OUTPUT_WIDTH < 1) begin : g_width_warn
    $warning("ffs_dec_m: OUTPUT_WIDTH < 1, using width 1");
  end

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [IDX_W:0]   C_W_EXT = (IDX_W+1)'(W);
  localparam logic [IDX_W-1:0] C_W_M1  = IDX_W'(W - 1);

  state_t          state_q;
  logic [W-1:0]    acc_q;
  logic            err_q;
  logic [W-1:0]    mask_q;
  logic            oerr_q;

  logic            in_range;
  logic [IDX_W-1:0] bit_pos;
  logic [W-1:0]    onehot;
  logic [W-1:0]    acc_d;
  logic            err_d;
  logic            accept;

  assign accept   = in_valid && (state_q == ACCUM);
  assign in_range = ({1'b0, in_idx} < C_W_EXT);
  // MSB-origin indexing mirrors the position; only meaningful when in range.
  assign bit_pos  = SIDE ? (C_W_M1 - in_idx) : in_idx;
  assign onehot   = in_range ? (W'(1) << bit_pos) : '0;
  assign acc_d    = acc_q | onehot;
  assign err_d    = err_q | ~in_range;

`ifdef FFS_DEC_DUP_CHECK_EN
  logic dup_q;
  logic odup_q;
  logic dup_d;

  assign dup_d = dup_q | (|(acc_q & onehot));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dup_q  <= 1'b0;
      odup_q <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        odup_q <= dup_d;
        dup_q  <= 1'b0;
      end else begin
        dup_q  <= dup_d;
      end
    end
  end

  assign out_dup = odup_q;
`else
  assign out_dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      err_q   <= 1'b0;
      mask_q  <= '0;
      oerr_q  <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              mask_q  <= acc_d;
              oerr_q  <= err_d;
              acc_q   <= '0;
              err_q   <= 1'b0;
              state_q <= HOLD;
            end else begin
              acc_q   <= acc_d;
              err_q   <= err_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign out_mask  = mask_q;
  assign out_err   = oerr_q;

endmodule
`default_nettype wire

// File: tb/tb_ffs_dec_m.sv
`default_nettype none
// Directed bench for ffs_dec_m: three instances (W=8 LSB, W=8 MSB, W=6 LSB)
// driven by shared stimulus, each checked against hand-computed masks.
module tb_ffs_dec_m;

`ifdef FFS_DEC_DUP_CHECK_EN
  localparam logic DUPEN = 1'b1;
`else
  localparam logic DUPEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_idx;
  logic       in_last;
  logic       out_ready;

  logic       rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [7:0] m0, m1;
  logic [5:0] m2;
  logic       dup0, dup1, dup2, err0, err1, err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ffs_dec_m #(.OUTPUT_WIDTH(8), .SIDE(1'b0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_idx(in_idx), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_mask(m0), .out_dup(dup0), .out_err(err0));

  ffs_dec_m #(.OUTPUT_WIDTH(8), .SIDE(1'b1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_idx(in_idx), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_mask(m1), .out_dup(dup1), .out_err(err1));

  ffs_dec_m #(.OUTPUT_WIDTH(6), .SIDE(1'b0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_idx(in_idx), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
    .out_mask(m2), .out_dup(dup2), .out_err(err2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [2:0] idx, input logic last);
    in_valid = 1'b1;
    in_idx   = idx;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_in_ready", {31'd0, rdy0}, 32'd1);
    chk("hs_out_valid", {31'd0, vld0}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, rdy0}, 32'd1);
    chk("rst_out_valid", {31'd0, vld0}, 32'd0);
    chk("rst_mask", {24'd0, m0}, 32'h0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_dup", {31'd0, dup0}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Packet A: 1,4,6(last)
    beat(3'd1, 1'b0);
    beat(3'd4, 1'b0);
    chk("A_pre_valid", {31'd0, vld0}, 32'd0);
    beat(3'd6, 1'b1);
    chk("A_valid_lat1", {31'd0, vld0}, 32'd1);
    chk("A_in_ready", {31'd0, rdy0}, 32'd0);
    chk("A_mask0", {24'd0, m0}, 32'h52);
    chk("A_mask1", {24'd0, m1}, 32'h4A);
    chk("A_mask2", {26'd0, m2}, 32'h12);
    chk("A_err0", {31'd0, err0}, 32'd0);
    chk("A_err2", {31'd0, err2}, 32'd1);
    chk("A_dup0", {31'd0, dup0}, 32'd0);
    handshake();

    // Packet B: single beat 0(last)
    beat(3'd0, 1'b1);
    chk("B_mask0", {24'd0, m0}, 32'h01);
    chk("B_mask1", {24'd0, m1}, 32'h80);
    chk("B_mask2", {26'd0, m2}, 32'h01);
    chk("B_err2", {31'd0, err2}, 32'd0);
    handshake();

    // Packet C: 3,3(last)
    beat(3'd3, 1'b0);
    beat(3'd3, 1'b1);
    chk("C_mask0", {24'd0, m0}, 32'h08);
    chk("C_mask1", {24'd0, m1}, 32'h10);
    chk("C_dup0", {31'd0, dup0}, {31'd0, DUPEN});
    chk("C_dup1", {31'd0, dup1}, {31'd0, DUPEN});
    chk("C_dup2", {31'd0, dup2}, {31'd0, DUPEN});
    chk("C_err0", {31'd0, err0}, 32'd0);
    handshake();

    // Packet D: 7,2(last); then stall in HOLD with in_valid asserted
    beat(3'd7, 1'b0);
    beat(3'd2, 1'b1);
    chk("D_mask0", {24'd0, m0}, 32'h84);
    chk("D_mask1", {24'd0, m1}, 32'h21);
    chk("D_mask2", {26'd0, m2}, 32'h04);
    chk("D_err2", {31'd0, err2}, 32'd1);
    chk("D_err0", {31'd0, err0}, 32'd0);
    chk("D_dup_cleared", {31'd0, dup0}, 32'd0);
    in_valid = 1'b1; in_idx = 3'd5; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("D_hold_in_ready", {31'd0, rdy0}, 32'd0);
      chk("D_hold_valid", {31'd0, vld0}, 32'd1);
      chk("D_hold_mask", {24'd0, m0}, 32'h84);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0; in_last = 1'b0;
    chk("D_reenter_ready", {31'd0, rdy0}, 32'd1);
    chk("D_reenter_valid", {31'd0, vld0}, 32'd0);

    // Packet E: 0,1 then async reset, then 2(last)
    beat(3'd0, 1'b0);
    beat(3'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("E_rst_mask", {24'd0, m0}, 32'h0);
    chk("E_rst_ready", {31'd0, rdy0}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("E_post_ready", {31'd0, rdy0}, 32'd1);
    chk("E_post_valid", {31'd0, vld0}, 32'd0);
    beat(3'd2, 1'b1);
    chk("E_mask0", {24'd0, m0}, 32'h04);
    chk("E_mask1", {24'd0, m1}, 32'h20);
    chk("E_mask2", {26'd0, m2}, 32'h04);
    chk("E_err0", {31'd0, err0}, 32'd0);
    handshake();

    // Packet F: 6,7(last) -- all out of range for W=6
    beat(3'd6, 1'b0);
    beat(3'd7, 1'b1);
    chk("F_mask2", {26'd0, m2}, 32'h00);
    chk("F_err2", {31'd0, err2}, 32'd1);
    chk("F_mask0", {24'd0, m0}, 32'hC0);
    chk("F_mask1", {24'd0, m1}, 32'h03);
    chk("F_err0", {31'd0, err0}, 32'd0);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
